// File: rtl/pool_layer_sequencer_if.sv
// Handshake and RAM/datapath bundle between the pooling sequencer and its peers.
// master: sequencer side (drives reads, ce, datapath reset, writes).
// slave:  RAM/datapath side (drives stall and pooled-result valid).
interface pool_layer_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              stall;
    logic              pool_out_valid;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              pool_ce;
    logic              pool_rst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;

    modport master (
        input  stall, pool_out_valid,
        output rd_en, rd_addr, pool_ce, pool_rst, wr_en, wr_addr
    );

    modport slave (
        output stall, pool_out_valid,
        input  rd_en, rd_addr, pool_ce, pool_rst, wr_en, wr_addr
    );
endinterface

// File: rtl/pool_layer_sequencer.sv
// Max-pool layer sequencer: per channel clears the datapath, streams the
// feature map from the input RAM and writes pooled results to the output RAM.
// Ports: clk, master_rst (sync, active high), start, bus (master modport:
// stall/pool_out_valid in; rd_en/rd_addr/pool_ce/pool_rst/wr_en/wr_addr out),
// ch_idx, busy, done, err (sticky drain timeout).
module pool_layer_sequencer #(
    parameter int INPUT_SIZE = 4,
    parameter int POOL_SIZE  = 2,
    parameter int NUM_CH     = 2,
    parameter int ADDR_W     = 8,
    parameter int DRAIN_MAX  = 16
) (
    input  logic                   clk,
    input  logic                   master_rst,
    input  logic                   start,
    pool_layer_sequencer_if.master bus,
    output logic [ADDR_W-1:0]      ch_idx,
    output logic                   busy,
    output logic                   done,
    output logic                   err
);
    localparam int NPIX = INPUT_SIZE * INPUT_SIZE;
    localparam int NOUT = (INPUT_SIZE / POOL_SIZE) * (INPUT_SIZE / POOL_SIZE);
    localparam int PW   = $clog2(NPIX + 1);
    localparam int OW   = $clog2(NOUT + 1);
    localparam int DW   = $clog2(DRAIN_MAX + 1);

    if (POOL_SIZE < 1 || INPUT_SIZE % POOL_SIZE != 0) begin : g_bad_size
        $error("INPUT_SIZE must be a positive multiple of POOL_SIZE");
    end
    if (64'(NUM_CH) * 64'(NPIX) > (64'd1 << ADDR_W)) begin : g_bad_addr
        $error("ADDR_W too narrow for NUM_CH*INPUT_SIZE^2");
    end
    if (NUM_CH < 1 || DRAIN_MAX < 1) begin : g_bad_cnt
        $error("NUM_CH and DRAIN_MAX must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, DONE} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] rd_ptr;
    logic [PW-1:0]     pix_cnt;
    logic [OW-1:0]     out_cnt;
    logic [DW-1:0]     drain_cnt;
    logic              issue, ch_adv, err_set;
    logic              last_pix, out_full;

    assign last_pix  = pix_cnt == PW'(NPIX - 1);
    assign out_full  = out_cnt == OW'(NOUT);
    assign bus.wr_en = bus.pool_out_valid && (state == STREAM || state == DRAIN);

    always_ff @(posedge clk) begin
        if (master_rst) state <= IDLE;
        else            state <= state_nxt;
    end

    // issue: a read is presented on rd_en/rd_addr in the following cycle.
    // CLEAR always issues the first read of a channel, so stall there is moot.
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        ch_adv    = 1'b0;
        err_set   = 1'b0;
        case (state)
            IDLE:   if (start) state_nxt = CLEAR;
            CLEAR: begin
                issue     = 1'b1;
                state_nxt = STREAM;
            end
            STREAM: begin
                if (last_pix) state_nxt = DRAIN;
                else          issue     = !bus.stall;
            end
            DRAIN: begin
                if (out_full) begin
                    if (ch_idx < ADDR_W'(NUM_CH - 1)) begin
                        ch_adv    = 1'b1;
                        state_nxt = CLEAR;
                    end else begin
                        state_nxt = DONE;
                    end
                end else if (drain_cnt == DW'(DRAIN_MAX - 1)) begin
                    err_set   = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (master_rst) begin
            bus.rd_en    <= 1'b0;
            bus.rd_addr  <= '0;
            bus.pool_ce  <= 1'b0;
            bus.pool_rst <= 1'b1;
            bus.wr_addr  <= '0;
            rd_ptr       <= '0;
            pix_cnt      <= '0;
            out_cnt      <= '0;
            drain_cnt    <= '0;
            ch_idx       <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
        end else begin
            bus.rd_en    <= issue;
            bus.pool_ce  <= bus.rd_en;
            bus.pool_rst <= state_nxt inside {IDLE, CLEAR, DONE};
            busy         <= state_nxt != IDLE;
            done         <= state_nxt == DONE;
            drain_cnt    <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;

            // rd_ptr is the next address; rd_addr holds the last issued one
            // so it stays put while stalled.
            if (issue) begin
                bus.rd_addr <= rd_ptr;
                rd_ptr      <= rd_ptr + 1'b1;
                pix_cnt     <= (state == CLEAR) ? '0 : pix_cnt + 1'b1;
            end

            if (state == CLEAR)  out_cnt <= '0;
            else if (bus.wr_en)  out_cnt <= out_cnt + 1'b1;
            if (bus.wr_en) bus.wr_addr <= bus.wr_addr + 1'b1;

            if (ch_adv)  ch_idx <= ch_idx + 1'b1;
            if (err_set) err    <= 1'b1;

            if (state == IDLE && start) begin
                ch_idx      <= '0;
                bus.rd_addr <= '0;
                rd_ptr      <= '0;
                bus.wr_addr <= '0;
                err         <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pool_layer_sequencer.sv
// Directed bench for pool_layer_sequencer (S=4, P=2, 2 channels).
// A small 2x2 pooling datapath model emits valid after pixels 5,7,13,15.
module tb_pool_layer_sequencer;
    logic       clk = 1'b0;
    logic       master_rst, start;
    logic [7:0] ch_idx;
    logic       busy, done, err;
    logic       stall_r, force_v, mv;
    int         vlimit;
    int         dce, dnv;

    int checks = 0;
    int errs   = 0;

    int rd_n = 0, ce_n = 0, wr_n = 0, dn_n = 0;
    int rd_bad = 0, wr_bad = 0, exp_rd = 0, exp_wr = 0;
    bit last_done_err = 1'b0;
    int s_rd, s_ce, s_wr, s_dn, s_rb, s_wb;

    int bc;
    bit ok, found;

    always #5 clk = ~clk;

    pool_layer_sequencer_if #(.ADDR_W(8)) bus ();

    assign bus.stall          = stall_r;
    assign bus.pool_out_valid = mv | force_v;

    pool_layer_sequencer #(
        .INPUT_SIZE(4), .POOL_SIZE(2), .NUM_CH(2), .ADDR_W(8), .DRAIN_MAX(16)
    ) dut (
        .clk(clk), .master_rst(master_rst), .start(start), .bus(bus),
        .ch_idx(ch_idx), .busy(busy), .done(done), .err(err)
    );

    // Datapath model: counts ce pulses since its reset.
    always @(posedge clk) begin
        if (bus.pool_rst) begin
            dce <= 0;
            dnv <= 0;
            mv  <= 1'b0;
        end else begin
            mv <= 1'b0;
            if (bus.pool_ce) begin
                dce <= dce + 1;
                if ((dce == 5 || dce == 7 || dce == 13 || dce == 15) && dnv < vlimit) begin
                    mv  <= 1'b1;
                    dnv <= dnv + 1;
                end
            end
        end
    end

    // Activity log: addresses must be contiguous from 0 after each start.
    always @(posedge clk) begin
        if (start && !busy && !master_rst) begin
            exp_rd = 0;
            exp_wr = 0;
        end
        if (bus.rd_en) begin
            if (int'(bus.rd_addr) != exp_rd) rd_bad++;
            exp_rd++;
            rd_n++;
        end
        if (bus.pool_ce) ce_n++;
        if (bus.wr_en) begin
            if (int'(bus.wr_addr) != exp_wr) wr_bad++;
            exp_wr++;
            wr_n++;
        end
        if (done) begin
            dn_n++;
            last_done_err = err;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        checks++;
        assert (obs === exp_v)
        else begin
            errs++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic snap();
        s_rd = rd_n; s_ce = ce_n; s_wr = wr_n;
        s_dn = dn_n; s_rb = rd_bad; s_wb = wr_bad;
    endtask

    task automatic wait_idle(input bit hold, input int bc_in, output int bc_o, output bit ok_o);
        bc_o = bc_in;
        ok_o = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = hold & busy;
            if (!busy) begin
                ok_o = 1'b1;
                break;
            end
            bc_o++;
        end
        start = 1'b0;
    endtask

    task automatic check_run(input string n, input bit ok_i, input int bc_i,
                             input int e_bc, input int e_rd, input int e_wr);
        chk({n, "_finished"}, 64'(ok_i), 1);
        chk({n, "_busy_cycles"}, 64'(bc_i), 64'(e_bc));
        chk({n, "_reads"}, 64'(rd_n - s_rd), 64'(e_rd));
        chk({n, "_ce_pulses"}, 64'(ce_n - s_ce), 64'(e_rd));
        chk({n, "_rd_order"}, 64'(rd_bad - s_rb), 0);
        chk({n, "_writes"}, 64'(wr_n - s_wr), 64'(e_wr));
        chk({n, "_wr_order"}, 64'(wr_bad - s_wb), 0);
        chk({n, "_done_pulses"}, 64'(dn_n - s_dn), 1);
    endtask

    task automatic check_reset(input string n);
        chk({n, "_flags"},
            {bus.rd_en, bus.pool_ce, bus.pool_rst, bus.wr_en, busy, done, err}, 7'b0010000);
        chk({n, "_rd_addr"}, bus.rd_addr, 0);
        chk({n, "_wr_addr"}, bus.wr_addr, 0);
        chk({n, "_ch_idx"}, ch_idx, 0);
    endtask

    initial begin
        master_rst = 1'b1;
        start      = 1'b0;
        stall_r    = 1'b0;
        force_v    = 1'b0;
        vlimit     = 4;
        repeat (2) @(negedge clk);
        check_reset("reset");
        master_rst = 1'b0;

        // valid in IDLE and CLEAR must not write
        force_v = 1'b1;
        @(negedge clk);
        chk("idle_wr_en", bus.wr_en, 0);
        snap();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("clear_ctl", {bus.wr_en, bus.pool_rst, busy, bus.rd_en, err}, 5'b01100);
        chk("clear_wr_addr", bus.wr_addr, 0);
        force_v = 1'b0;
        @(negedge clk);
        chk("first_read", {bus.rd_en, bus.rd_addr, bus.pool_ce, bus.pool_rst},
            {1'b1, 8'd0, 1'b0, 1'b0});
        @(negedge clk);
        chk("first_ce", {bus.rd_en, bus.rd_addr, bus.pool_ce}, {1'b1, 8'd1, 1'b1});
        wait_idle(1'b0, 3, bc, ok);
        check_run("run1", ok, bc, 41, 32, 8);
        chk("run1_end", {bus.wr_addr, ch_idx, err, last_done_err},
            {8'd8, 8'd1, 1'b0, 1'b0});

        // stall for 3 cycles while the read of pixel 5 is on the bus
        snap();
        start = 1'b1;
        bc    = 0;
        ok    = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
            bc++;
            if (!found && bus.rd_en && bus.rd_addr == 8'd5) begin
                found   = 1'b1;
                stall_r = 1'b1;
                @(negedge clk);
                bc++;
                chk("stall_c1", {bus.rd_en, bus.rd_addr, bus.pool_ce}, {1'b0, 8'd5, 1'b1});
                @(negedge clk);
                bc++;
                chk("stall_c2", {bus.rd_en, bus.rd_addr, bus.pool_ce}, {1'b0, 8'd5, 1'b0});
                @(negedge clk);
                bc++;
                chk("stall_c3", {bus.rd_en, bus.rd_addr, bus.pool_ce}, {1'b0, 8'd5, 1'b0});
                stall_r = 1'b0;
                @(negedge clk);
                bc++;
                chk("stall_resume", {bus.rd_en, bus.rd_addr, bus.pool_ce}, {1'b1, 8'd6, 1'b0});
            end
        end
        stall_r = 1'b0;
        chk("stall_hit", 64'(found), 1);
        check_run("stall", ok, bc, 44, 32, 8);

        // start held high whenever busy: no restart
        snap();
        start = 1'b1;
        wait_idle(1'b1, 0, bc, ok);
        repeat (5) @(negedge clk);
        chk("restart_idle", {busy, done}, 2'b00);
        check_run("restart", ok, bc, 41, 32, 8);

        // master_rst at pixel 9 of channel 1
        start = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            start = 1'b0;
            if (bus.rd_en && bus.rd_addr == 8'd25) begin
                found = 1'b1;
                break;
            end
        end
        chk("mrst_hit", {64'(found)}, {63'd0, 1'b1});
        chk("mrst_ch", ch_idx, 1);
        master_rst = 1'b1;
        @(negedge clk);
        check_reset("mrst");
        master_rst = 1'b0;
        @(negedge clk);
        snap();
        start = 1'b1;
        wait_idle(1'b0, 0, bc, ok);
        check_run("after_mrst", ok, bc, 41, 32, 8);

        // only 3 valids in channel 0: drain timeout
        vlimit = 3;
        snap();
        start = 1'b1;
        wait_idle(1'b0, 0, bc, ok);
        check_run("timeout", ok, bc, 34, 16, 3);
        chk("timeout_done_err", 64'(last_done_err), 1);
        chk("timeout_ch", ch_idx, 0);
        repeat (3) @(negedge clk);
        chk("err_sticky", err, 1);
        vlimit = 4;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("err_cleared", {err, busy}, 2'b01);
        wait_idle(1'b0, 1, bc, ok);
        chk("final_run", {64'(ok), 64'(bc)}, {64'd1, 64'd41});
        chk("final_err", err, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
